// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman codebook generator.
//   - huff_state_t : top-level phase of the generator
//   - huff_node_t  : per-slot merge-tree node {weight, active, group}
//   - len_w/code_w/wt_w : derive field widths from NSYM and FREQ_W
// The node struct uses a fixed weight width large enough for FREQ_W up to 16
// with NSYM up to 16; the generator narrows merged sums to its own WT_W.
package huff_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MERGE = 2'd1,
        CANON = 2'd2,
        EMIT  = 2'd3
    } huff_state_t;

    localparam int NODE_WT_W  = 20;
    localparam int NODE_GRP_W = 4;

    typedef struct packed {
        logic [NODE_WT_W-1:0]  weight;
        logic                  active;
        logic [NODE_GRP_W-1:0] group;
    } huff_node_t;

    // Code-length field width; also wide enough to index NSYM slots.
    function automatic int len_w(input int nsym);
        return $clog2(nsym);
    endfunction

    // Longest possible Huffman code for nsym symbols.
    function automatic int code_w(input int nsym);
        return nsym - 1;
    endfunction

    // Merged weight never exceeds nsym * (2**freq_w - 1).
    function automatic int wt_w(input int nsym, input int freq_w);
        return freq_w + $clog2(nsym);
    endfunction

endpackage

// File: rtl/huff_min2.sv
// Combinational selector of the two lowest-weight active slots.
//   weight[NSYM] : slot weights
//   active       : slot-active mask
//   a, b         : indices of the two minimum active slots, a < b
// Ranking is by weight; equal weights rank the lower index first.
module huff_min2
    import huff_pkg::*;
#(
    parameter  int NSYM  = 4,
    parameter  int WT_W  = NODE_WT_W,
    localparam int IDX_W = $clog2(NSYM)
) (
    input  logic [WT_W-1:0]  weight [NSYM],
    input  logic [NSYM-1:0]  active,
    output logic [IDX_W-1:0] a,
    output logic [IDX_W-1:0] b
);

    logic             found1, found2;
    logic [IDX_W-1:0] min1, min2;
    logic [WT_W-1:0]  wt1, wt2;

    // Ascending scan with strict compares keeps the earlier index on ties.
    always_comb begin
        found1 = 1'b0;
        found2 = 1'b0;
        min1   = '0;
        min2   = '0;
        wt1    = '0;
        wt2    = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (active[i]) begin
                if (!found1 || weight[i] < wt1) begin
                    min2   = min1;
                    wt2    = wt1;
                    found2 = found1;
                    min1   = IDX_W'(i);
                    wt1    = weight[i];
                    found1 = 1'b1;
                end else if (!found2 || weight[i] < wt2) begin
                    min2   = IDX_W'(i);
                    wt2    = weight[i];
                    found2 = 1'b1;
                end
            end
        end
        a = (min1 < min2) ? min1 : min2;
        b = (min1 < min2) ? min2 : min1;
    end

endmodule

// File: rtl/huff_codebook_gen.sv
// Huffman codebook generator.
// Loads NSYM (symbol, frequency) pairs, builds code lengths with one merge per
// cycle, assigns canonical codes by a length-major scan, then streams one
// (symbol, code, length) record per input symbol in input order.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_sym/in_freq : load stream (in_ready high in LOAD)
//   out_valid/out_ready/out_sym/out_code/out_len : record stream
//   busy : high in MERGE, CANON, EMIT
//   done : one-cycle pulse after the last record is accepted
module huff_codebook_gen
    import huff_pkg::*;
#(
    parameter  int NSYM   = 4,
    parameter  int SYM_W  = 8,
    parameter  int FREQ_W = 4,
    localparam int LEN_W  = len_w(NSYM),
    localparam int CODE_W = code_w(NSYM),
    localparam int WT_W   = wt_w(NSYM, FREQ_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SYM_W-1:0]  in_sym,
    input  logic [FREQ_W-1:0] in_freq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SYM_W-1:0]  out_sym,
    output logic [CODE_W-1:0] out_code,
    output logic [LEN_W-1:0]  out_len,
    output logic              busy,
    output logic              done
);

    localparam int               IDX_W    = LEN_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);
    localparam logic [IDX_W-1:0] LAST_MRG = IDX_W'(NSYM - 2);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(CODE_W);

    huff_state_t state_reg, state_next;

    logic [IDX_W-1:0]  load_idx_reg, merge_cnt_reg, scan_idx_reg, emit_idx_reg;
    logic [LEN_W-1:0]  cur_len_reg;
    logic [CODE_W-1:0] next_code_reg;

    logic [SYM_W-1:0]  sym_mem  [NSYM];
    logic [LEN_W-1:0]  len_mem  [NSYM];
    logic [CODE_W-1:0] code_mem [NSYM];
    huff_node_t        node     [NSYM];

    logic [NODE_WT_W-1:0] weight_vec [NSYM];
    logic [NSYM-1:0]      active_vec;
    logic [IDX_W-1:0]     min_a, min_b;
    logic [WT_W-1:0]      merged_wt;
    logic                 scan_hit;
    logic [CODE_W-1:0]    code_inc;
    logic                 out_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NSYM; gi++) begin : g_vec
            assign weight_vec[gi] = node[gi].weight;
            assign active_vec[gi] = node[gi].active;
        end
    endgenerate

    huff_min2 #(
        .NSYM (NSYM),
        .WT_W (NODE_WT_W)
    ) u_min2 (
        .weight (weight_vec),
        .active (active_vec),
        .a      (min_a),
        .b      (min_b)
    );

    assign merged_wt = WT_W'(node[min_a].weight + node[min_b].weight);
    assign scan_hit  = (len_mem[scan_idx_reg] == cur_len_reg);
    assign code_inc  = next_code_reg + CODE_W'(scan_hit);
    assign out_fire  = out_valid && out_ready;

    assign in_ready = (state_reg == LOAD);
    assign busy     = (state_reg != LOAD);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= LOAD;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:  if (in_valid && load_idx_reg == LAST_IDX) state_next = MERGE;
            MERGE: if (merge_cnt_reg == LAST_MRG)            state_next = CANON;
            CANON: if (cur_len_reg == MAX_LEN && scan_idx_reg == LAST_IDX)
                       state_next = EMIT;
            EMIT:  if (out_fire && emit_idx_reg == LAST_IDX) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_idx_reg  <= '0;
            merge_cnt_reg <= '0;
            scan_idx_reg  <= '0;
            emit_idx_reg  <= '0;
            cur_len_reg   <= '0;
            next_code_reg <= '0;
            out_valid     <= 1'b0;
            out_sym       <= '0;
            out_code      <= '0;
            out_len       <= '0;
            done          <= 1'b0;
            for (int s = 0; s < NSYM; s++) begin
                sym_mem[s]  <= '0;
                len_mem[s]  <= '0;
                code_mem[s] <= '0;
                node[s]     <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state_reg)
                LOAD: begin
                    if (in_valid) begin
                        sym_mem[load_idx_reg] <= in_sym;
                        len_mem[load_idx_reg] <= '0;
                        node[load_idx_reg]    <= '{weight: NODE_WT_W'(in_freq),
                                                   active: 1'b1,
                                                   group:  NODE_GRP_W'(load_idx_reg)};
                        load_idx_reg  <= (load_idx_reg == LAST_IDX) ? '0 : load_idx_reg + 1'b1;
                        merge_cnt_reg <= '0;
                    end
                end
                MERGE: begin
                    node[min_a].weight <= NODE_WT_W'(merged_wt);
                    node[min_b].active <= 1'b0;
                    // Every symbol in either merged subtree moves one level deeper.
                    for (int s = 0; s < NSYM; s++) begin
                        if (node[s].group == NODE_GRP_W'(min_a) ||
                            node[s].group == NODE_GRP_W'(min_b)) begin
                            len_mem[s]    <= len_mem[s] + LEN_W'(1);
                            node[s].group <= NODE_GRP_W'(min_a);
                        end
                    end
                    merge_cnt_reg <= merge_cnt_reg + 1'b1;
                    if (merge_cnt_reg == LAST_MRG) begin
                        cur_len_reg   <= LEN_W'(1);
                        scan_idx_reg  <= '0;
                        next_code_reg <= '0;
                    end
                end
                CANON: begin
                    if (scan_hit) code_mem[scan_idx_reg] <= next_code_reg;
                    // End of a length pass: the first code of the next length
                    // is the successor of the last one, shifted left.
                    if (scan_idx_reg == LAST_IDX) begin
                        scan_idx_reg  <= '0;
                        cur_len_reg   <= cur_len_reg + LEN_W'(1);
                        next_code_reg <= code_inc << 1;
                    end else begin
                        scan_idx_reg  <= scan_idx_reg + 1'b1;
                        next_code_reg <= code_inc;
                    end
                    emit_idx_reg <= '0;
                end
                EMIT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_sym   <= sym_mem[emit_idx_reg];
                        out_code  <= code_mem[emit_idx_reg];
                        out_len   <= len_mem[emit_idx_reg];
                    end else if (out_ready) begin
                        if (emit_idx_reg == LAST_IDX) begin
                            out_valid    <= 1'b0;
                            done         <= 1'b1;
                            emit_idx_reg <= '0;
                        end else begin
                            emit_idx_reg <= emit_idx_reg + 1'b1;
                            out_sym      <= sym_mem[emit_idx_reg + 1'b1];
                            out_code     <= code_mem[emit_idx_reg + 1'b1];
                            out_len      <= len_mem[emit_idx_reg + 1'b1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_codebook_gen.sv
module tb_huff_codebook_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_sym;
    logic [3:0] in_freq;
    logic       out_ready;
    logic       use2;

    logic       in_ready4, out_valid4, busy4, done4;
    logic [7:0] out_sym4;
    logic [2:0] out_code4;
    logic [1:0] out_len4;

    logic       in_ready2, out_valid2, busy2, done2;
    logic [7:0] out_sym2;
    logic [0:0] out_code2;
    logic [0:0] out_len2;

    logic       v_in_ready, v_out_valid, v_busy, v_done;
    logic [7:0] v_out_sym;
    logic [2:0] v_out_code;
    logic [1:0] v_out_len;

    int checks = 0;
    int errors = 0;

    int         freq_tab [16];
    logic [7:0] sym_tab  [16];
    int         exp_len  [16];
    int         exp_code [16];

    always #5 clk = ~clk;

    huff_codebook_gen #(.NSYM(4), .SYM_W(8), .FREQ_W(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && !use2), .in_ready(in_ready4),
        .in_sym(in_sym), .in_freq(in_freq),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_sym(out_sym4), .out_code(out_code4), .out_len(out_len4),
        .busy(busy4), .done(done4)
    );

    huff_codebook_gen #(.NSYM(2), .SYM_W(8), .FREQ_W(4)) u_dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && use2), .in_ready(in_ready2),
        .in_sym(in_sym), .in_freq(in_freq),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_sym(out_sym2), .out_code(out_code2), .out_len(out_len2),
        .busy(busy2), .done(done2)
    );

    assign v_in_ready  = use2 ? in_ready2  : in_ready4;
    assign v_out_valid = use2 ? out_valid2 : out_valid4;
    assign v_busy      = use2 ? busy2      : busy4;
    assign v_done      = use2 ? done2      : done4;
    assign v_out_sym   = use2 ? out_sym2   : out_sym4;
    assign v_out_code  = use2 ? {2'b00, out_code2} : out_code4;
    assign v_out_len   = use2 ? {1'b0, out_len2}   : out_len4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: Huffman over clusters ranked by (weight, lowest member),
    // followed by textbook canonical numbering in (length, index) order.
    task automatic build_model(input int n);
        int w [16];
        int mem [16];
        bit alive [16];
        int keys [$];
        int p, q, a, b, c;
        for (int i = 0; i < n; i++) begin
            w[i] = freq_tab[i]; mem[i] = 1 << i; alive[i] = 1'b1; exp_len[i] = 0;
        end
        for (int m = 0; m < n - 1; m++) begin
            keys.delete();
            for (int i = 0; i < n; i++)
                if (alive[i]) keys.push_back(w[i] * 32 + i);
            keys.sort();
            p = keys[0] % 32;
            q = keys[1] % 32;
            a = (p < q) ? p : q;
            b = (p < q) ? q : p;
            for (int s = 0; s < n; s++)
                if (((mem[a] | mem[b]) >> s) & 1) exp_len[s]++;
            mem[a] |= mem[b];
            w[a] += w[b];
            alive[b] = 1'b0;
        end
        c = 0;
        for (int len = 1; len < n; len++) begin
            for (int i = 0; i < n; i++)
                if (exp_len[i] == len) begin exp_code[i] = c; c++; end
            c = c << 1;
        end
    endtask

    task automatic set4(input int f0, f1, f2, f3);
        freq_tab[0] = f0; freq_tab[1] = f1; freq_tab[2] = f2; freq_tab[3] = f3;
        for (int i = 0; i < 4; i++) sym_tab[i] = 8'h41 + 8'(i);
    endtask

    task automatic set_exp(input int i, input int len, input int code);
        exp_len[i] = len; exp_code[i] = code;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sym   = sym_tab[i];
            in_freq  = 4'(freq_tab[i]);
            chk("in_ready_load", v_in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("in_ready_after_load", v_in_ready, 0);
        chk("busy_after_load", v_busy, 1);
    endtask

    task automatic wait_first(input int n);
        int cyc = 0;
        while (!v_out_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("first_valid_latency", cyc, 1 + (n - 1) + (n - 1) * n);
    endtask

    task automatic collect(input int n, input int mode);
        int got = 0;
        int c = 0;
        bit last_fire;
        while (got < n && c < 300) begin
            if (mode == 1) out_ready = (c >= 5 && c < 10) ? 1'b0 : (c % 2 == 0);
            else           out_ready = 1'b1;
            if (v_out_valid) begin
                chk("rec_sym",  v_out_sym,  sym_tab[got]);
                chk("rec_code", v_out_code, exp_code[got]);
                chk("rec_len",  v_out_len,  exp_len[got]);
            end
            last_fire = v_out_valid && out_ready && (got == n - 1);
            if (v_out_valid && out_ready) got++;
            @(posedge clk); #1;
            c++;
            chk("done_pulse", v_done, last_fire);
        end
        chk("records_accepted", got, n);
        $display("codebook n=%0d mode=%0d records=%0d cycles=%0d", n, mode, got, c);
        out_ready = 1'b0;
        chk("out_valid_after", v_out_valid, 0);
        chk("in_ready_after", v_in_ready, 1);
        @(posedge clk); #1;
        chk("done_cleared", v_done, 0);
    endtask

    task automatic run(input int n, input int mode);
        load(n);
        wait_first(n);
        collect(n, mode);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sym = '0; in_freq = '0;
        out_ready = 1'b0; use2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready4, 1);
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_busy",      busy4, 0);
        chk("rst_done",      done4, 0);
        chk("rst_out_fields", {out_sym4, out_code4, out_len4}, 0);
        chk("rst_out_valid2", out_valid2, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready4, 1);

        // 5,1,1,2 -> A:0/1 B:110/3 C:111/3 D:10/2
        set4(5, 1, 1, 2);
        set_exp(0, 1, 0); set_exp(1, 3, 6); set_exp(2, 3, 7); set_exp(3, 2, 2);
        run(4, 0);

        // all ones -> 00,01,10,11
        set4(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) set_exp(i, 2, i);
        run(4, 0);

        // 8,4,2,1 -> 0,10,110,111
        set4(8, 4, 2, 1);
        set_exp(0, 1, 0); set_exp(1, 2, 2); set_exp(2, 3, 6); set_exp(3, 3, 7);
        run(4, 0);

        // backpressure with the first codebook
        set4(5, 1, 1, 2);
        set_exp(0, 1, 0); set_exp(1, 3, 6); set_exp(2, 3, 7); set_exp(3, 2, 2);
        run(4, 1);

        // reset during MERGE aborts without output
        set4(7, 3, 9, 2);
        load(4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", v_busy, 0);
        chk("abort_in_ready", v_in_ready, 1);
        begin
            int stale = 0;
            for (int k = 0; k < 20; k++) begin
                if (v_out_valid) stale++;
                @(posedge clk); #1;
            end
            chk("abort_no_output", stale, 0);
        end
        set4(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) set_exp(i, 2, i);
        run(4, 0);

        // randomized codebooks against the reference model
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) begin
                freq_tab[i] = int'($urandom_range(0, 15));
                sym_tab[i]  = 8'($urandom_range(0, 255));
            end
            build_model(4);
            run(4, int'($urandom_range(0, 1)));
        end

        // two-symbol instance: 3,0 -> codes 0 and 1, both length 1
        use2 = 1'b1;
        @(posedge clk); #1;
        freq_tab[0] = 3; freq_tab[1] = 0;
        sym_tab[0] = 8'h41; sym_tab[1] = 8'h42;
        set_exp(0, 1, 0); set_exp(1, 1, 1);
        run(2, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 2; i++) begin
                freq_tab[i] = int'($urandom_range(0, 15));
                sym_tab[i]  = 8'($urandom_range(0, 255));
            end
            build_model(2);
            run(2, int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
